// File: rtl/k12a_sequencer_if.sv
// K12A sequencer state type and the decoder <-> sequencer interface.
// The slave side is the sequencer. The master side is the decoder/datapath.

package k12a_seq_pkg;
   typedef enum logic [2:0] {
      STATE_FETCH1 = 3'd0,
      STATE_FETCH2 = 3'd1,
      STATE_FETCH3 = 3'd2,
      STATE_EXEC   = 3'd3,
      STATE_POP    = 3'd4,
      STATE_RJMP   = 3'd5,
      STATE_HALT   = 3'd6,
      STATE_IRQ    = 3'd7
   } state_t;
endpackage

interface k12a_sequencer_if;
   import k12a_seq_pkg::*;

   state_t dec_next_state;
   logic   dec_mem_enable;
   logic   mem_ready;
   logic   wake;
   logic   irq;
   logic   irq_mask;
   state_t state;
   logic   commit;
   logic   mem_hold;
   logic   irq_ack;
   logic   bus_error;
   logic   halted;

   modport master (
      output dec_next_state, dec_mem_enable, mem_ready, wake, irq, irq_mask,
      input  state, commit, mem_hold, irq_ack, bus_error, halted
   );

   modport slave (
      input  dec_next_state, dec_mem_enable, mem_ready, wake, irq, irq_mask,
      output state, commit, mem_hold, irq_ack, bus_error, halted
   );
endinterface

// File: rtl/k12a_sequencer.sv
// K12A state register and cycle sequencer.
// The sequencer decides when the decoder's next_state is taken. Memory states are
// stretched for wait states and mem_ready, and are aborted into HALT on timeout.
// HALT is left on wake or on an interrupt. An interrupt is entered only at an
// EXEC->FETCH1 boundary, or directly from HALT.
//
//  state        | meaning
//  STATE_FETCH1 | first fetch cycle, reset target
//  STATE_FETCH2 | second fetch cycle
//  STATE_FETCH3 | third fetch cycle
//  STATE_EXEC   | execute; irq entry is checked on its commit to FETCH1
//  STATE_POP    | stack pop, never interrupted
//  STATE_RJMP   | relative jump, never interrupted
//  STATE_HALT   | stopped; left on wake_s or an unmasked irq_s
//  STATE_IRQ    | interrupt vector entry (push pc), then FETCH1

module k12a_sequencer
   import k12a_seq_pkg::*;
#(
   parameter int MEM_WAIT    = 0,
   parameter int MEM_TIMEOUT = 64,
   parameter int WAKE_SYNC   = 2,
   parameter int IRQ_ENABLE  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   k12a_sequencer_if.slave   bus_if
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   state_t                state_q, state_d;
   logic [CW-1:0]         wait_q, wait_d;
   logic                  irq_ack_q, irq_ack_d;
   logic                  bus_error_q, bus_error_d;
   logic [WAKE_SYNC-1:0]  wake_sync_q, irq_sync_q;
   logic                  wake_s, irq_s, irq_take, wait_met, commit_c, mem_hold_c;

   assign wake_s   = wake_sync_q[WAKE_SYNC-1];
   assign irq_s    = irq_sync_q[WAKE_SYNC-1];
   assign irq_take = irq_s & ~bus_if.irq_mask & (IRQ_ENABLE != 0);

   // With no wait states the minimum-hold condition is always satisfied.
   if (MEM_WAIT == 0) begin : g_no_wait
      assign wait_met = 1'b1;
   end else begin : g_wait
      assign wait_met = (wait_q >= CW'(MEM_WAIT));
   end

   // Synchronise the asynchronous wake and irq inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wake_sync_q <= '0;
         irq_sync_q  <= '0;
      end else begin
         for (int i = WAKE_SYNC - 1; i > 0; i--) begin
            wake_sync_q[i] <= wake_sync_q[i-1];
            irq_sync_q[i]  <= irq_sync_q[i-1];
         end
         wake_sync_q[0] <= bus_if.wake;
         irq_sync_q[0]  <= bus_if.irq;
      end
   end

   // State register, wait counter and the one-cycle event pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= STATE_FETCH1;
         wait_q      <= '0;
         irq_ack_q   <= 1'b0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         irq_ack_q   <= irq_ack_d;
         bus_error_q <= bus_error_d;
      end
   end

   // Decide commit/stretch, the next state and the pending pulses.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      commit_c    = 1'b0;
      mem_hold_c  = 1'b0;
      irq_ack_d   = 1'b0;
      bus_error_d = 1'b0;
      if (state_q == STATE_HALT) begin
         commit_c = 1'b1;
         wait_d   = '0;
         // The interrupt takes priority over wake when both arrive together.
         if (irq_take) begin
            state_d   = STATE_IRQ;
            irq_ack_d = 1'b1;
         end else if (wake_s) begin
            state_d = STATE_FETCH1;
         end
      end else begin
         if (bus_if.dec_mem_enable) begin
            commit_c   = wait_met & bus_if.mem_ready;
            mem_hold_c = ~commit_c;
         end else begin
            commit_c = 1'b1;
         end
         if (commit_c) begin
            wait_d = '0;
            if (state_q == STATE_EXEC && bus_if.dec_next_state == STATE_FETCH1 && irq_take) begin
               state_d   = STATE_IRQ;
               irq_ack_d = 1'b1;
            end else begin
               state_d = bus_if.dec_next_state;
            end
         end else if (wait_q == CW'(MEM_TIMEOUT - 1)) begin
            // Abort without committing, so no register store happens.
            bus_error_d = 1'b1;
            state_d     = STATE_HALT;
            wait_d      = '0;
         end else if (wait_q != CW'(MEM_TIMEOUT)) begin
            wait_d = wait_q + CW'(1);
         end
      end
   end

   assign bus_if.state     = state_q;
   assign bus_if.commit    = commit_c;
   assign bus_if.mem_hold  = mem_hold_c;
   assign bus_if.irq_ack   = irq_ack_q;
   assign bus_if.bus_error = bus_error_q;
   assign bus_if.halted    = (state_q == STATE_HALT);

endmodule
